lcm_stage: RTL and testbench

Downstream consumer of the 8-bit subtractive GCD unit. It takes the operand pair and the GCD that unit produces on its ack, and computes LCM = (A*B)/gcd. It uses a sequential shift-add multiplier followed by a restoring shift-subtract divider. It follows the same start/ack handshake style as the GCD unit, so the two can be chained: GCD ack drives lcm_stage start.

---
 rtl/lcm_pkg.sv | 23 ++
 rtl/lcm_stage_div.sv | 48 ++++
 rtl/lcm_stage.sv | 145 ++++++++++++++
 tb/tb_lcm_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcm_pkg.sv
// lcm_pkg: shared types and constants for the LCM stage.
package lcm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int MUL_CYCLES = DEF_WIDTH;
  localparam int DIV_CYCLES = 2 * DEF_WIDTH;

  function automatic int mul_cycles(input int w);
    return w;
  endfunction

  function automatic int div_cycles(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/lcm_stage_div.sv
// shift_sub_div: restoring divider, one quotient bit per step.
// Dividend is 2*WIDTH bits, divisor WIDTH bits.
module shift_sub_div
  import lcm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder
);

  logic [WIDTH:0]     rem_q;
  logic [2*WIDTH-1:0] quo_q;
  logic [WIDTH-1:0]   dvsr_q;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic               neg;

  // remainder stays below divisor, so WIDTH+1 bits hold the shift
  assign shifted = {rem_q[WIDTH-1:0], quo_q[2*WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dvsr_q};
  assign neg     = diff[WIDTH+1];

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else if (load) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvsr_q <= divisor;
    end else if (step) begin
      rem_q  <= neg ? shifted : diff[WIDTH:0];
      quo_q  <= {quo_q[2*WIDTH-2:0], ~neg};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q[WIDTH-1:0];

endmodule

// File: rtl/lcm_stage.sv
// lcm_stage: LCM = A*B/gcd via shift-add multiply then restoring divide.
// Optional LCM_ZERO_BYPASS_EN: zero operand skips straight to DONE.
module lcm_stage
  import lcm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   gcd,
  output logic               busy,
  output logic               ack,
  output logic [2*WIDTH-1:0] rez,
  output logic               err
);

  localparam int MUL_N = mul_cycles(WIDTH);
  localparam int DIV_N = div_cycles(WIDTH);
  localparam int CW    = $clog2(DIV_N);

  state_t             state_q;
  state_t             state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   mplr_q;
  logic [WIDTH-1:0]   gcd_q;
  logic               zero_q;
  logic               accept;
  logic               bypass;
  logic               mul_last;
  logic               div_last;
  logic               div_load;
  logic               div_step;
  logic [2*WIDTH-1:0] div_quo;
  logic [WIDTH-1:0]   div_rem_unused;

  // the ack cycle is not an accept cycle; start is taken one edge later
  assign accept = (state_q == ST_IDLE) && start && !ack;

`ifdef LCM_ZERO_BYPASS_EN
  assign bypass = (gcd != '0) && ((A == '0) || (B == '0));
`else
  assign bypass = 1'b0;
`endif

  assign prod_d   = mplr_q[0] ? prod_q + mcand_q : prod_q;
  assign mul_last = (cnt_q == CW'(MUL_N - 1));
  assign div_last = (cnt_q == CW'(DIV_N - 1));

  always_ff @(posedge Clk) begin
    if (!Rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    div_load = 1'b0;
    div_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if ((gcd == '0) || bypass) state_d = ST_DONE;
          else                       state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          state_d  = ST_DIV;
          div_load = 1'b1;
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (div_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      mplr_q  <= '0;
      gcd_q   <= '0;
      zero_q  <= 1'b0;
      busy    <= 1'b0;
      ack     <= 1'b0;
      rez     <= '0;
      err     <= 1'b0;
    end else begin
      ack <= (state_q == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            mcand_q <= {{WIDTH{1'b0}}, A};
            mplr_q  <= B;
            gcd_q   <= gcd;
            prod_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= (gcd == '0) || bypass;
            rez     <= '0;
            err     <= (gcd == '0);
            busy    <= 1'b1;
          end
        end
        ST_MUL: begin
          prod_q  <= prod_d;
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_q >> 1;
          cnt_q   <= mul_last ? '0 : cnt_q + CW'(1);
        end
        ST_DIV: begin
          cnt_q <= div_last ? '0 : cnt_q + CW'(1);
        end
        ST_DONE: begin
          rez  <= zero_q ? '0 : div_quo;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  shift_sub_div #(
    .WIDTH(WIDTH)
  ) u_div (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .load     (div_load),
    .step     (div_step),
    .dividend (prod_d),
    .divisor  (gcd_q),
    .quotient (div_quo),
    .remainder(div_rem_unused)
  );

endmodule

// File: tb/tb_lcm_stage.sv
// tb_lcm_stage: directed checks of lcm_stage, incl. a chained GCD model.
module tb_lcm_stage;
  import lcm_pkg::*;

`ifdef LCM_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 25;
`endif

  logic        Clk;
  logic        Rst_n;
  logic        st_drv;
  logic [7:0]  a_drv, b_drv, g_drv;
  logic        d_start;
  logic [7:0]  d_a, d_b, d_g;
  logic        busy, ack, err;
  logic [15:0] rez;
  logic        chain;

  logic        gst, g_busy, g_ack;
  logic [7:0]  gi_a, gi_b, g_a, g_b, g_x, g_y, g_res;

  int total, bad;

  assign d_start = chain ? g_ack : st_drv;
  assign d_a     = chain ? g_a   : a_drv;
  assign d_b     = chain ? g_b   : b_drv;
  assign d_g     = chain ? g_res : g_drv;

  lcm_stage #(.WIDTH(8)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .start(d_start),
    .A    (d_a),
    .B    (d_b),
    .gcd  (d_g),
    .busy (busy),
    .ack  (ack),
    .rez  (rez),
    .err  (err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // subtractive GCD reference standing in for the upstream unit
  always @(posedge Clk) begin
    if (!Rst_n) begin
      g_busy <= 1'b0;
      g_ack  <= 1'b0;
      g_res  <= '0;
      g_a    <= '0;
      g_b    <= '0;
      g_x    <= '0;
      g_y    <= '0;
    end else begin
      g_ack <= 1'b0;
      if (!g_busy && gst) begin
        g_a <= gi_a; g_b <= gi_b;
        g_x <= gi_a; g_y <= gi_b;
        g_busy <= 1'b1;
      end else if (g_busy) begin
        if (g_x == g_y) begin
          g_res  <= g_x;
          g_ack  <= 1'b1;
          g_busy <= 1'b0;
        end else if (g_x > g_y) g_x <= g_x - g_y;
        else                    g_y <= g_y - g_x;
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] g);
    a_drv = a; b_drv = b; g_drv = g; st_drv = 1'b1;
    tick();
    st_drv = 1'b0;
  endtask

  task automatic wait_ack(input string tag, input int base, input int lat,
                          input logic [15:0] er, input logic ee);
    int n;
    bit seen;
    n = base;
    seen = 0;
    while (n < 60 && !seen) begin
      tick();
      n++;
      if (ack === 1'b1) seen = 1;
    end
    chk({tag, "_lat"}, seen ? n : -1, lat);
    chk({tag, "_rez"}, 32'(rez), 32'(er));
    chk({tag, "_err"}, 32'(err), 32'(ee));
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic post_ack(input string tag, input logic [15:0] er);
    tick();
    chk({tag, "_ack1"}, 32'(ack), 0);
    chk({tag, "_hold"}, 32'(rez), 32'(er));
  endtask

  initial begin
    int na, ng, nl;
    logic [15:0] r;
    total = 0; bad = 0;
    chain = 1'b0; gst = 1'b0; gi_a = '0; gi_b = '0;
    Rst_n = 1'b0; st_drv = 1'b0;
    a_drv = '0; b_drv = '0; g_drv = '0;
    tick(); tick();
    Rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rez", 32'(rez), 0);
    chk("rst_err", 32'(err), 0);

    launch(8'd2, 8'd6, 8'd2);
    chk("basic_busy", 32'(busy), 1);
    wait_ack("basic", 0, 25, 16'd6, 1'b0);
    post_ack("basic", 16'd6);

    launch(8'd255, 8'd254, 8'd1);
    wait_ack("max", 0, 25, 16'd64770, 1'b0);
    post_ack("max", 16'd64770);

    launch(8'd12, 8'd18, 8'd6);
    wait_ack("l36", 0, 25, 16'd36, 1'b0);
    post_ack("l36", 16'd36);

    launch(8'd5, 8'd7, 8'd0);
    chk("z_busy", 32'(busy), 1);
    wait_ack("zgcd", 0, 1, 16'd0, 1'b1);
    post_ack("zgcd", 16'd0);
    launch(8'd3, 8'd4, 8'd1);
    chk("clr_err", 32'(err), 0);
    wait_ack("after_z", 0, 25, 16'd12, 1'b0);
    post_ack("after_z", 16'd12);

    launch(8'd4, 8'd6, 8'd2);
    repeat (9) tick();
    a_drv = 8'd9; b_drv = 8'd9; g_drv = 8'd9; st_drv = 1'b1;
    tick();
    st_drv = 1'b0;
    chk("bp_busy", 32'(busy), 1);
    wait_ack("bp", 10, 25, 16'd12, 1'b0);
    post_ack("bp", 16'd12);

    launch(8'd4, 8'd6, 8'd2);
    repeat (14) tick();
    Rst_n = 1'b0;
    tick();
    chk("ab_busy", 32'(busy), 0);
    chk("ab_ack", 32'(ack), 0);
    chk("ab_rez", 32'(rez), 0);
    chk("ab_state", 32'(dut.state_q), 32'(ST_IDLE));
    Rst_n = 1'b1;
    na = 0;
    repeat (40) begin
      tick();
      if (ack === 1'b1) na++;
    end
    chk("ab_noack", na, 0);

    launch(8'd0, 8'd9, 8'd9);
    wait_ack("zop", 0, ZLAT, 16'd0, 1'b0);
    post_ack("zop", 16'd0);

    launch(8'd1, 8'd1, 8'd1);
    wait_ack("b2b0", 0, 25, 16'd1, 1'b0);
    a_drv = 8'd3; b_drv = 8'd5; g_drv = 8'd1; st_drv = 1'b1;
    tick();
    chk("b2b_rej", 32'(busy), 0);
    tick();
    st_drv = 1'b0;
    chk("b2b_acc", 32'(busy), 1);
    wait_ack("b2b1", 0, 25, 16'd15, 1'b0);
    post_ack("b2b1", 16'd15);

    chain = 1'b1;
    gi_a = 8'd2; gi_b = 8'd6; gst = 1'b1;
    tick();
    gst = 1'b0;
    ng = 0; nl = 0; r = '0;
    repeat (60) begin
      tick();
      if (g_ack === 1'b1) ng++;
      if (ack === 1'b1) begin nl++; r = rez; end
    end
    chk("ch1_gack", ng, 1);
    chk("ch1_lack", nl, 1);
    chk("ch1_rez", 32'(r), 6);

    gi_a = 8'd4; gi_b = 8'd6; gst = 1'b1;
    tick();
    gst = 1'b0;
    ng = 0; nl = 0; r = '0;
    repeat (60) begin
      tick();
      if (g_ack === 1'b1) ng++;
      if (ack === 1'b1) begin nl++; r = rez; end
    end
    chk("ch2_gack", ng, 1);
    chk("ch2_lack", nl, 1);
    chk("ch2_rez", 32'(r), 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
